// File: rtl/pmu_batch_sequencer.sv
// Host-side batch sequencer for the lane-parallel PMU wrapper: serial operand load, compute
// trigger, then serial readout re-emitted as a tagged valid/ready result stream.
module pmu_batch_sequencer #(
   parameter  int NUM_LANES  = 240,
   parameter  int DATA_WIDTH = 16,
   parameter  int PMU_LAT    = 2,
   localparam int LW         = $clog2(NUM_LANES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_a,
   input  logic [DATA_WIDTH-1:0] s_b,
   output logic                  pmu_rst,
   output logic                  pmu_load_en,
   output logic [DATA_WIDTH-1:0] pmu_dinA,
   output logic [DATA_WIDTH-1:0] pmu_dinB,
   output logic                  pmu_compute_start,
   output logic                  pmu_read_en,
   input  logic [DATA_WIDTH:0]   pmu_dout,
   input  logic                  pmu_valid,
   input  logic                  pmu_done,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH:0]   m_data,
   output logic [LW-1:0]         m_index,
   output logic                  m_last,
   output logic                  busy,
   output logic                  err
);

   localparam int KW = $clog2(NUM_LANES + 1);
   localparam int SW = (PMU_LAT > 1) ? $clog2(PMU_LAT + 1) : 1;
   localparam logic [KW-1:0] K_LAST      = KW'(NUM_LANES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(PMU_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_SETTLE, S_COMPUTE, S_WAIT, S_READ
   } state_t;

   state_t                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic [SW-1:0]         settle_q, settle_d;
   logic                  m_valid_q, m_valid_d;
   logic [DATA_WIDTH:0]   m_data_q, m_data_d;
   logic [LW-1:0]         m_index_q, m_index_d;
   logic                  m_last_q, m_last_d;
   logic                  err_q, err_d;
   logic                  slot_free;
   logic                  k_is_last;

   assign slot_free   = !m_valid_q || m_ready;
   assign k_is_last   = (k_q == K_LAST);
   assign pmu_rst     = rst || (state_q == S_CLEAR);
   assign pmu_load_en = s_valid && s_ready;
   assign pmu_dinA    = s_a;
   assign pmu_dinB    = s_b;
   assign busy        = (state_q != S_IDLE);
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_index     = m_index_q;
   assign m_last      = m_last_q;
   assign err         = err_q;

   always_comb begin
      state_d           = state_q;
      k_d               = k_q;
      settle_d          = settle_q;
      m_valid_d         = m_valid_q;
      m_data_d          = m_data_q;
      m_index_d         = m_index_q;
      m_last_d          = m_last_q;
      err_d             = err_q;
      s_ready           = 1'b0;
      pmu_compute_start = 1'b0;
      pmu_read_en       = 1'b0;

      // Output slot drains independently of the FSM; a READ load below overrides this.
      if (m_ready) m_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (s_valid) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            k_d     = '0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (k_is_last) begin
                  k_d      = '0;
                  settle_d = '0;
                  state_d  = (PMU_LAT == 0) ? S_COMPUTE : S_SETTLE;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (settle_q == SETTLE_LAST) state_d = S_COMPUTE;
            else                         settle_d = settle_q + 1'b1;
         end
         S_COMPUTE: begin
            pmu_compute_start = 1'b1;
            state_d           = S_WAIT;
         end
         S_WAIT: begin
            if (pmu_valid) state_d = S_READ;
         end
         S_READ: begin
            if (slot_free) begin
               m_valid_d = 1'b1;
               m_data_d  = pmu_dout;
               m_index_d = k_q[LW-1:0];
               m_last_d  = k_is_last;
               if ((pmu_done != k_is_last) || !pmu_valid) err_d = 1'b1;
               // The wrapper pointer must not run past the final lane.
               if (k_is_last) begin
                  k_d     = '0;
                  state_d = S_IDLE;
               end else begin
                  pmu_read_en = 1'b1;
                  k_d         = k_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         settle_q  <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_index_q <= '0;
         m_last_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         settle_q  <= settle_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_index_q <= m_index_d;
         m_last_q  <= m_last_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_pmu_batch_sequencer.sv
// Bench for pmu_batch_sequencer: a behavioural wrapper model plus a scoreboard of expected
// lane results built from the operands driven in, checked on every accepted output beat.
module tb_pmu_batch_sequencer;

   localparam int N   = 240;
   localparam int DW  = 16;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid, s_ready;
   logic [DW-1:0] s_a, s_b;
   logic          pmu_rst, pmu_load_en, pmu_compute_start, pmu_read_en;
   logic [DW-1:0] pmu_dinA, pmu_dinB;
   logic [DW:0]   pmu_dout;
   logic          pmu_valid, pmu_done;
   logic          m_valid, m_ready, m_last, busy, err;
   logic [DW:0]   m_data;
   logic [7:0]    m_index;

   always #5 clk = ~clk;

   pmu_batch_sequencer #(.NUM_LANES(N), .DATA_WIDTH(DW), .PMU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .pmu_rst(pmu_rst), .pmu_load_en(pmu_load_en), .pmu_dinA(pmu_dinA), .pmu_dinB(pmu_dinB),
      .pmu_compute_start(pmu_compute_start), .pmu_read_en(pmu_read_en), .pmu_dout(pmu_dout),
      .pmu_valid(pmu_valid), .pmu_done(pmu_done), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_index(m_index), .m_last(m_last), .busy(busy), .err(err)
   );

   // Wrapper model: serial write pointer, parallel A+B at compute_start, serial read pointer.
   logic [DW-1:0] mem_a [N];
   logic [DW-1:0] mem_b [N];
   logic [DW:0]   res   [N];
   int            wp, rp, force_lane;
   logic          rv;

   always @(posedge clk) begin
      if (pmu_rst) begin
         wp <= 0; rp <= 0; rv <= 1'b0;
      end else begin
         if (pmu_load_en && wp < N) begin
            mem_a[wp] <= pmu_dinA;
            mem_b[wp] <= pmu_dinB;
            wp        <= wp + 1;
         end
         if (pmu_compute_start) begin
            for (int i = 0; i < N; i++) res[i] <= {1'b0, mem_a[i]} + {1'b0, mem_b[i]};
            rv <= 1'b1;
            rp <= 0;
         end else if (pmu_read_en && rp < N - 1) begin
            rp <= rp + 1;
         end
      end
   end

   assign pmu_dout  = res[rp];
   assign pmu_valid = rv;
   assign pmu_done  = rv && (rp == N - 1 || rp == force_lane);

   int          n_cmp = 0, n_fail = 0;
   int          cyc = 0, last_load_cyc = 0, load_cnt = 0, rd_cnt = 0;
   int          beats_seen = 0, exp_target = 0, cur_kind = 0;
   bit          clr_seen = 0, rdy_rand = 0, prev_hold = 0;
   logic [DW:0] prev_data;
   logic [7:0]  prev_idx;
   logic [DW:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: event did not occur within its bound (cycle %0d)", name, cyc);
   endtask

   // Compare process: protocol rules plus scoreboard on each accepted beat.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 0; clr_seen = 0; load_cnt = 0;
      end else begin
         int          idx;
         logic [DW:0] e;
         if (pmu_rst) begin clr_seen = 1; load_cnt = 0; end
         if (pmu_load_en) begin load_cnt++; last_load_cyc = cyc; end
         if (pmu_read_en) begin
            rd_cnt++;
            check("read_en_slot_free", 32'(!m_valid || m_ready), 1);
         end
         if (pmu_compute_start) begin
            check("start_delay", 32'(cyc - last_load_cyc), LAT + 1);
            check("loads_before_start", 32'(load_cnt), N);
            check("clear_before_start", 32'(clr_seen), 1);
            clr_seen = 0;
            rd_cnt   = 0;
         end
         if (prev_hold) begin
            check("hold_valid", 32'(m_valid), 1);
            check("hold_data", 32'(m_data), 32'(prev_data));
            check("hold_index", 32'(m_index), 32'(prev_idx));
         end
         if (m_valid && m_ready) begin
            idx = beats_seen % N;
            if (exp_q.size() == 0) begin
               fail_now("unexpected_beat");
            end else begin
               e = exp_q.pop_front();
               check("m_data", 32'(m_data), 32'(e));
            end
            check("m_index", 32'(m_index), 32'(idx));
            check("m_last", 32'(m_last), 32'(idx == N - 1));
            check("err", 32'(err), 32'(force_lane >= 0 && idx >= force_lane));
            case (cur_kind)
               0: check("pin_3i", 32'(m_data), 32'(3 * idx));
               1: check("pin_max", 32'(m_data), 32'h1FFFE);
               2: check("pin_zero", 32'(m_data), 32'h0);
               default: ;
            endcase
            if (idx == N - 1) check("read_en_count", 32'(rd_cnt), N - 1);
            beats_seen++;
         end
         prev_hold = m_valid && !m_ready;
         prev_data = m_data;
         prev_idx  = m_index;
      end
   end

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // kind: 0 A=i,B=2i; 1 all-ones; 2 zeros; 3 random. abort_at >= 0 resets after that lane.
   task automatic run_batch(input int kind, input bit gap, input int abort_at);
      logic [DW:0] exp_l [N];
      logic [DW-1:0] a, b;
      bit acc;
      int budget;
      cur_kind = kind;
      for (int i = 0; i < N; i++) begin
         if (gap && i > 0) begin s_valid = 1'b0; @(posedge clk); #1; end
         case (kind)
            0: begin a = DW'(i); b = DW'(2 * i); end
            1: begin a = 16'hFFFF; b = 16'hFFFF; end
            2: begin a = '0; b = '0; end
            default: begin a = DW'($urandom); b = DW'($urandom); end
         endcase
         s_a = a; s_b = b; s_valid = 1'b1;
         exp_l[i] = {1'b0, a} + {1'b0, b};
         budget = 0;
         do begin
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1; budget++;
         end while (!acc && budget < 50);
         if (!acc) begin fail_now("load_handshake"); s_valid = 1'b0; return; end
         if (i == abort_at) begin
            rst = 1'b1; s_valid = 1'b0;
            @(negedge clk);
            check("abort_pmu_rst", 32'(pmu_rst), 1);
            @(posedge clk); #1; rst = 1'b0;
            @(negedge clk);
            check("abort_busy", 32'(busy), 0);
            check("abort_m_valid", 32'(m_valid), 0);
            check("abort_s_ready", 32'(s_ready), 0);
            return;
         end
      end
      s_valid = 1'b0;
      for (int i = 0; i < N; i++) exp_q.push_back(exp_l[i]);
      exp_target += N;
      budget = 0;
      while (beats_seen < exp_target && budget < 4000) begin @(posedge clk); budget++; end
      if (beats_seen < exp_target) fail_now("batch_readout");
      #1;
   endtask

   initial begin
      force_lane = -1;
      rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pmu_rst", 32'(pmu_rst), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_load_en", 32'(pmu_load_en), 0);
      check("rst_start", 32'(pmu_compute_start), 0);
      check("rst_read_en", 32'(pmu_read_en), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_m_index", 32'(m_index), 0);
      check("rst_m_last", 32'(m_last), 0);
      check("rst_err", 32'(err), 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("idle_pmu_rst", 32'(pmu_rst), 0);
      check("idle_busy", 32'(busy), 0);
      @(posedge clk); #1;

      run_batch(0, 0, -1);
      rdy_rand = 1; run_batch(3, 0, -1); rdy_rand = 0;
      run_batch(0, 1, -1);
      run_batch(0, 0, 100);
      run_batch(3, 0, -1);

      force_lane = 10;
      run_batch(0, 0, -1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("err_sticky", 32'(err), 1);
      check("err_idle_busy", 32'(busy), 0);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; force_lane = -1;
      @(negedge clk);
      check("err_cleared", 32'(err), 0);
      @(posedge clk); #1;

      rdy_rand = 1;
      run_batch(1, 0, -1);
      run_batch(2, 0, -1);
      rdy_rand = 0;
      repeat (5) @(posedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      check("total_beats", 32'(beats_seen), 7 * N);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
